// File: rtl/gpio_apb_arbiter_if.sv
// APB pin bundle between the arbiter (master)
// and the GPIO peripheral (slave).
interface gpio_apb_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/gpio_apb_arbiter.sv
// Two-requester round-robin APB master in front
// of the GPIO slave, with ACCESS-phase timeout.
module gpio_apb_arbiter #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  gpio_apb_arbiter_if.master apb
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, DONE
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              err0_q, err0_d;
  logic              err1_q, err1_d;
  logic              gnt;
  logic              fin;
  logic              tout;

  // Next-state: arbitration, command latch, ready/timeout handling
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    err0_d   = err0_q;
    err1_d   = err1_q;
    gnt      = 1'b0;
    fin      = 1'b0;
    tout     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // on a tie the port that did not win last time goes next
          gnt      = (req0 && req1) ? ~last_q : req1;
          owner_d  = gnt;
          last_d   = gnt;
          pwrite_d = gnt ? we1 : we0;
          paddr_d  = gnt ? addr1 : addr0;
          pwdata_d = gnt ? wdata1 : wdata0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (apb.PREADY) begin
          fin = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          fin  = 1'b1;
          tout = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (fin) begin
          state_d = DONE;
          if (owner_q) begin
            err1_d = tout;
            if (tout)          rdata1_d = '0;
            else if (!pwrite_q) rdata1_d = apb.PRDATA;
          end else begin
            err0_d = tout;
            if (tout)          rdata0_d = '0;
            else if (!pwrite_q) rdata0_d = apb.PRDATA;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
    end
  end

  assign apb.PSEL    = (state_q == SETUP) || (state_q == ACCESS);
  assign apb.PENABLE = (state_q == ACCESS);
  assign apb.PWRITE  = pwrite_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;

  assign done0  = (state_q == DONE) && !owner_q;
  assign done1  = (state_q == DONE) && owner_q;
  assign err0   = err0_q;
  assign err1   = err1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Bench for gpio_apb_arbiter: directed table,
// corner sequences, randomized scoreboard.
module tb_gpio_apb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [3:0]  addr [2];
  logic [31:0] wdata [2];
  logic        done0_w, done1_w, err0_w, err1_w;
  logic [31:0] rdata0_w, rdata1_w;
  logic [1:0]  done, err;
  logic [31:0] rdata [2];
  logic        hang = 1'b0;
  logic        pready_q = 1'b0;
  logic [31:0] regs [16];

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] mem_m [16];
  logic [31:0] rd_m [2];

  gpio_apb_arbiter_if #(.ADDR_W(4), .DATA_W(32)) apb ();

  gpio_apb_arbiter #(.ADDR_W(4), .DATA_W(32), .TIMEOUT(16)) dut (
    .PCLK(clk), .PRESET(rst),
    .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]),
    .done0(done0_w), .err0(err0_w), .rdata0(rdata0_w),
    .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]),
    .done1(done1_w), .err1(err1_w), .rdata1(rdata1_w),
    .apb(apb.master)
  );

  assign done = {done1_w, done0_w};
  assign err  = {err1_w, err0_w};
  assign rdata[0] = rdata0_w;
  assign rdata[1] = rdata1_w;

  always #5 clk = ~clk;

  // GPIO slave model: PREADY one cycle into ACCESS
  initial for (int i = 0; i < 16; i++) regs[i] = '0;
  always @(posedge clk) begin
    pready_q <= apb.PSEL && apb.PENABLE && !pready_q;
    if (apb.PSEL && apb.PENABLE && apb.PREADY && apb.PWRITE)
      regs[apb.PADDR] <= apb.PWDATA;
  end
  assign apb.PREADY = pready_q && !hang;
  assign apb.PRDATA = regs[apb.PADDR];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_m[0] = '0;
    rd_m[1] = '0;
  endtask

  task automatic do_xfer(input int p, input logic w,
                         input logic [3:0] a, input logic [31:0] wd,
                         output int cyc, output logic [31:0] rd,
                         output logic er, output int en_cnt,
                         output int other, output logic cmd_ok);
    cyc = 0; rd = '0; er = 1'b0;
    en_cnt = 0; other = 0; cmd_ok = 1'b1;
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = wd;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (apb.PENABLE) begin
        en_cnt++;
        if (apb.PADDR !== a || apb.PWRITE !== w ||
            (w && apb.PWDATA !== wd)) cmd_ok = 1'b0;
      end
      if (done[1-p]) other++;
      if (done[p]) begin
        cyc = i; rd = rdata[p]; er = err[p];
        break;
      end
    end
    req[p] = 1'b0;
    if (w && cyc != 0 && !er) mem_m[a] = wd;
  endtask

  typedef struct {
    int          p;
    logic        w;
    logic [3:0]  a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [8];

  initial begin
    int cyc, en, oth;
    logic [31:0] rd;
    logic er, ok;
    int order [$];
    int when [$];
    int age [2];
    int oth_cnt [2];
    logic [31:0] exp;

    vt[0] = '{0, 1'b1, 4'h0, 32'h0000_00FF, 32'h0};
    vt[1] = '{0, 1'b1, 4'h8, 32'h0000_00A5, 32'h0};
    vt[2] = '{1, 1'b0, 4'h8, 32'h0,         32'h0000_00A5};
    vt[3] = '{1, 1'b0, 4'h0, 32'h0,         32'h0000_00FF};
    vt[4] = '{0, 1'b1, 4'h4, 32'h1234_5678, 32'h0};
    vt[5] = '{0, 1'b0, 4'h4, 32'h0,         32'h1234_5678};
    vt[6] = '{1, 1'b1, 4'h8, 32'hDEAD_BEEF, 32'h0000_00FF};
    vt[7] = '{0, 1'b0, 4'h8, 32'h0,         32'hDEAD_BEEF};

    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    addr[0] = '0; addr[1] = '0;
    wdata[0] = '0; wdata[1] = '0;
    @(negedge clk);
    do_reset();

    chk("reset_outs",
        {done, err, rdata[0], rdata[1][15:0], apb.PSEL, apb.PENABLE,
         apb.PWRITE, apb.PADDR},
        64'h0);
    chk("reset_pwdata", {32'h0, apb.PWDATA}, 64'h0);

    for (int i = 0; i < 8; i++) begin
      do_xfer(vt[i].p, vt[i].w, vt[i].a, vt[i].wd, cyc, rd, er, en, oth, ok);
      chk($sformatf("vec%0d_lat", i), cyc, 4);
      chk($sformatf("vec%0d_en", i), en, 2);
      chk($sformatf("vec%0d_cmd", i), ok, 1);
      chk($sformatf("vec%0d_other_done", i), oth, 0);
      chk($sformatf("vec%0d_err", i), er, 0);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      @(negedge clk);
    end
    chk("slave_cr", regs[0], 32'hFF);

    hang = 1'b1;
    do_xfer(0, 1'b0, 4'h0, 32'h0, cyc, rd, er, en, oth, ok);
    chk("tout_en_cycles", en, 16);
    chk("tout_lat", cyc, 18);
    chk("tout_err", er, 1);
    chk("tout_rdata", rd, 0);
    hang = 1'b0;
    @(negedge clk);
    do_xfer(0, 1'b0, 4'h0, 32'h0, cyc, rd, er, en, oth, ok);
    chk("after_tout_err", er, 0);
    chk("after_tout_rdata", rd, mem_m[0]);
    @(negedge clk);

    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 4'h8;
    ok = 1'b1; cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (apb.PENABLE) begin
        if (apb.PADDR !== 4'h8) ok = 1'b0;
        addr[0] = 4'h4;
      end
      if (done[0]) begin
        cyc = i; rd = rdata[0];
        break;
      end
    end
    req[0] = 1'b0;
    chk("cmdchg_paddr_held", ok, 1);
    chk("cmdchg_lat", cyc, 4);
    chk("cmdchg_rdata", rd, mem_m[8]);

    do_reset();
    req = 2'b11; we = 2'b00; addr[0] = 4'h0; addr[1] = 4'h8;
    for (int i = 1; i <= 40 && order.size() < 4; i++) begin
      @(negedge clk);
      if (done[0] && done[1]) chk("sim_overlap", done, 2'b01);
      for (int k = 0; k < 2; k++)
        if (done[k]) begin
          order.push_back(k);
          when.push_back(i);
          chk($sformatf("sim_rdata%0d", order.size()), rdata[k],
              mem_m[addr[k]]);
        end
    end
    req = 2'b00;
    chk("sim_count", order.size(), 4);
    for (int i = 0; i < order.size(); i++) begin
      chk($sformatf("sim_order%0d", i), order[i], i % 2);
      chk($sformatf("sim_when%0d", i), when[i], 4 + 5 * i);
    end
    @(negedge clk);

    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 4'h4;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = apb.PENABLE;
    end
    chk("rst_mid_reached_access", ok, 1);
    rst = 1'b1; req[0] = 1'b0;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 4'h8;
    @(negedge clk);
    chk("rst_mid_bus", {apb.PSEL, apb.PENABLE, done}, 4'b0);
    rst = 1'b0;
    rd_m[0] = '0; rd_m[1] = '0;
    cyc = 0; oth = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done[0]) oth++;
      if (done[1]) begin
        cyc = i; rd = rdata[1]; er = err[1];
        break;
      end
    end
    req[1] = 1'b0;
    chk("rst_mid_req1_lat", cyc, 4);
    chk("rst_mid_req1_rdata", rd, mem_m[8]);
    chk("rst_mid_req1_err", er, 0);
    chk("rst_mid_no_done0", oth, 0);

    do_reset();
    age[0] = 0; age[1] = 0;
    oth_cnt[0] = 0; oth_cnt[1] = 0;
    for (int c = 0; c < 600; c++) begin
      logic [1:0] fin;
      @(negedge clk);
      fin = '0;
      if (done[0] && done[1]) chk("rnd_overlap", done, 2'b01);
      for (int k = 0; k < 2; k++) begin
        if (done[k]) begin
          fin[k] = 1'b1;
          chk("rnd_done_owner_req", req[k], 1);
          chk("rnd_err", err[k], 0);
          chk("rnd_fair", oth_cnt[k] <= 1, 1);
          if (we[k]) begin
            exp = rd_m[k];
            mem_m[addr[k]] = wdata[k];
          end else begin
            exp = mem_m[addr[k]];
            rd_m[k] = exp;
          end
          chk($sformatf("rnd_rdata%0d", k), rdata[k], exp);
          if (req[1-k]) oth_cnt[1-k]++;
          req[k] = 1'b0;
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (req[k]) begin
          age[k]++;
          if (age[k] > 12) begin
            chk($sformatf("rnd_starve%0d", k), age[k], 12);
            age[k] = 0;
          end
        end else if (!fin[k] && c < 560 && $urandom_range(0, 2) == 0) begin
          req[k] = 1'b1;
          we[k] = 1'($urandom_range(0, 1));
          addr[k] = 4'($urandom_range(0, 15));
          wdata[k] = $urandom;
          age[k] = 0;
          oth_cnt[k] = 0;
        end
      end
    end
    chk("rnd_drained", req, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
